// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier:
//   - default parameter constants for the array and datapath widths
//   - FSM state enumeration used by the top-level controller
package systolic_pkg;

  localparam int unsigned N_DEF      = 3;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned ACC_W_DEF  = 16;
  localparam int unsigned K_MAX_DEF  = 16;
  localparam bit          SIGNED_DEF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate processing element of the systolic array.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr_i      synchronous clear of accumulator and sticky overflow
//   a_i, b_i   operands arriving from the left / from above
//   a_o, b_o   operands registered one hop to the right / downward
//   acc_o      running accumulator (wraps modulo 2^ACC_W)
//   ovf_o      sticky overflow flag (carry-out or signed overflow)
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter bit          SIGNED = SIGNED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [DW-1:0]    a_o,
  output logic [DW-1:0]    b_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);

  logic [DW-1:0]    a_q, b_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W:0]   sum;
  logic             add_ovf;

  // Operands are extended to ACC_W before multiplying; the low ACC_W bits
  // equal the 2*DW-bit product extended per SIGNED.
  always_comb begin
    a_ext   = {{(ACC_W-DW){SIGNED & a_i[DW-1]}}, a_i};
    b_ext   = {{(ACC_W-DW){SIGNED & b_i[DW-1]}}, b_i};
    prod    = a_ext * b_ext;
    sum     = {1'b0, acc_q} + {1'b0, prod};
    if (SIGNED)
      add_ovf = (acc_q[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    else
      add_ovf = sum[ACC_W];
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | add_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/systolic_matmul.sv
// Output-stationary N x N systolic matrix multiplier, C = A * B.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, k_len          begin a multiply of inner dimension k_len (IDLE only)
//   in_valid, in_ready    beat handshake; a_col = column k of A, b_row = row k of B
//   out_valid, out_ready  result handshake; c holds C[i][j] at (i*N+j)*ACC_W
//   busy                  high whenever not IDLE
//   ovf                   sticky accumulator overflow of the current run
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned K_MAX  = K_MAX_DEF,
  parameter bit          SIGNED = SIGNED_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*DW-1:0]            a_col,
  input  logic [N*DW-1:0]            b_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*N*ACC_W-1:0]       c,
  output logic                       busy,
  output logic                       ovf
);

  localparam int unsigned KW  = $clog2(K_MAX+1);
  localparam int unsigned DRW = $clog2(2*N);

  state_e         state_q, state_d;
  logic [KW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  klen_q, klen_d;
  logic [DRW-1:0] drn_q, drn_d;
  logic           clr;
  logic           hs;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    klen_d    = klen_q;
    drn_d     = drn_q;
    clr       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr    = 1'b1;
          klen_d = k_len;
          cnt_d  = '0;
          state_d = (k_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q + KW'(1);
          if ((cnt_q + KW'(1)) == klen_q) begin
            drn_d   = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Last beat reaches PE(N-1,N-1) 2N-2 edges after acceptance;
        // one extra cycle gives DONE on edge 2N-1.
        drn_d = drn_q + DRW'(1);
        if (drn_q == DRW'(2*N-2)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- operand injection and skew ----------------
  assign hs = (state_q == ST_LOAD) && in_valid;

  logic [DW-1:0] a_inj [N];
  logic [DW-1:0] b_inj [N];
  logic [DW-1:0] a_sk  [N];
  logic [DW-1:0] b_sk  [N];

  // Non-handshake cycles inject zeros so gaps act as bubbles.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_inj[i] = hs ? a_col[i*DW +: DW] : '0;
      b_inj[i] = hs ? b_row[i*DW +: DW] : '0;
    end
  end

  assign a_sk[0] = a_inj[0];
  assign b_sk[0] = b_inj[0];

  for (genvar gi = 1; gi < N; gi++) begin : g_skew
    logic [DW-1:0] a_sr [gi];
    logic [DW-1:0] b_sr [gi];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned s = 0; s < gi; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else begin
        a_sr[0] <= a_inj[gi];
        b_sr[0] <= b_inj[gi];
        for (int unsigned s = 1; s < gi; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end
    assign a_sk[gi] = a_sr[gi-1];
    assign b_sk[gi] = b_sr[gi-1];
  end

  // ---------------- PE grid ----------------
  logic [DW-1:0] a_h [N][N+1];
  logic [DW-1:0] b_v [N+1][N];
  logic [N*N-1:0] ovf_pe;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    assign a_h[gi][0] = a_sk[gi];
    assign b_v[0][gi] = b_sk[gi];
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(
        .DW     (DW),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .a_i   (a_h[gi][gj]),
        .b_i   (b_v[gi][gj]),
        .a_o   (a_h[gi][gj+1]),
        .b_o   (b_v[gi+1][gj]),
        .acc_o (c[(gi*N+gj)*ACC_W +: ACC_W]),
        .ovf_o (ovf_pe[gi*N+gj])
      );
    end
  end

  assign ovf = |ovf_pe;

endmodule

// File: tb/tb_systolic_matmul.sv
module tb_systolic_matmul;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int ACC_W = 16;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX+1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*DW-1:0]      a_col;
  logic [N*DW-1:0]      b_row;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*N*ACC_W-1:0] c;
  logic                 busy;
  logic                 ovf;

  systolic_matmul #(
    .N      (N),
    .DW     (DW),
    .ACC_W  (ACC_W),
    .K_MAX  (K_MAX),
    .SIGNED (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col     (a_col),
    .b_row     (b_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Current run operands: A[i][k] = opa[k][i], B[k][j] = opb[k][j].
  int unsigned opa [K_MAX][N];
  int unsigned opb [K_MAX][N];
  longint      expc [N][N];
  bit          expo;

  typedef struct {
    int          k;
    int          gap;
    int unsigned a  [4][3];
    int unsigned b  [4][3];
    longint      ec [3][3];
    bit          eo;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: C = A*B as plain integer sums; unsigned wrap at 2^16 and
  // overflow whenever the exact sum exceeds the accumulator range.
  task automatic compute_ref(input int k);
    expo = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(opa[kk][i]) * longint'(opb[kk][j]);
        if (s >= 65536) expo = 1'b1;
        expc[i][j] = s % 65536;
      end
  endtask

  function automatic logic [N*N*ACC_W-1:0] exp_flat();
    logic [N*N*ACC_W-1:0] f;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) f[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(expc[i][j]);
    return f;
  endfunction

  task automatic feed_beats(input int from, input int to, input int gap);
    for (int b = from; b < to; b++) begin
      if (b > 0)
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          a_col = (N*DW)'($urandom);
          b_row = (N*DW)'($urandom);
          step();
        end
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = DW'(opa[b][i]);
        b_row[i*DW +: DW] = DW'(opb[b][i]);
      end
      chk("in_ready_load", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    a_col = '0;
    b_row = '0;
  endtask

  task automatic run(input string tag, input int k, input int gap);
    int lat;
    start = 1'b1;
    k_len = KW'(k);
    step();
    start = 1'b0;
    feed_beats(0, k, gap);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, (k == 0) ? 0 : 2*N-1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), c[(i*N+j)*ACC_W +: ACC_W], expc[i][j]);
    chk({tag, "_ovf"}, ovf, expo);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    chk({tag, "_busy_done"}, busy, 1);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_out_valid_idle"}, out_valid, 0);
    chk({tag, "_c_retained"}, (c == exp_flat()), 1);
  endtask

  task automatic load_vec(input int v);
    for (int kk = 0; kk < vt[v].k; kk++)
      for (int i = 0; i < N; i++) begin
        opa[kk][i] = vt[v].a[kk][i];
        opb[kk][i] = vt[v].b[kk][i];
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) expc[i][j] = vt[v].ec[i][j];
    expo = vt[v].eo;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_col = '0; b_row = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_c_zero", (c == '0), 1);
    rst = 1'b0;
    step();

    // Vector table: basic, stalled, overflow, small after overflow, empty.
    for (int kk = 0; kk < 3; kk++)
      for (int x = 0; x < 3; x++) begin
        vt[0].a[kk][x] = 3*x + kk + 1;
        vt[0].b[kk][x] = 3*kk + x + 1;
      end
    vt[0].k = 3; vt[0].gap = 0; vt[0].eo = 1'b0;
    vt[0].ec = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    vt[1] = vt[0];
    vt[1].gap = 2;
    vt[2].k = 2; vt[2].gap = 0; vt[2].eo = 1'b1;
    for (int kk = 0; kk < 2; kk++)
      for (int x = 0; x < 3; x++) begin
        vt[2].a[kk][x] = 255;
        vt[2].b[kk][x] = 255;
      end
    vt[2].ec = '{'{64514, 64514, 64514}, '{64514, 64514, 64514}, '{64514, 64514, 64514}};
    vt[3].k = 4; vt[3].gap = 1; vt[3].eo = 1'b0;
    for (int kk = 0; kk < 4; kk++)
      for (int x = 0; x < 3; x++) begin
        vt[3].a[kk][x] = 1;
        vt[3].b[kk][x] = 2;
      end
    vt[3].ec = '{'{8, 8, 8}, '{8, 8, 8}, '{8, 8, 8}};
    vt[4].k = 0; vt[4].gap = 0; vt[4].eo = 1'b0;
    vt[4].ec = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run($sformatf("vec%0d", v), vt[v].k, vt[v].gap);
      release_result($sformatf("vec%0d", v));
    end

    // Randomised runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      int k;
      int maxv;
      k = $urandom_range(1, K_MAX);
      maxv = (r % 2 == 0) ? 15 : 255;
      for (int kk = 0; kk < k; kk++)
        for (int x = 0; x < N; x++) begin
          opa[kk][x] = $urandom_range(0, maxv);
          opb[kk][x] = $urandom_range(0, maxv);
        end
      compute_ref(k);
      run($sformatf("rnd%0d", r), k, $urandom_range(0, 2));
      release_result($sformatf("rnd%0d", r));
    end

    // Backpressure: result held, start ignored while DONE.
    load_vec(0);
    run("bp", 3, 0);
    for (int t = 0; t < 10; t++) begin
      start = 1'b1;
      k_len = KW'(1);
      in_valid = 1'b1;
      step();
      chk($sformatf("bp_out_valid_%0d", t), out_valid, 1);
      chk($sformatf("bp_in_ready_%0d", t), in_ready, 0);
      chk($sformatf("bp_c_stable_%0d", t), (c == exp_flat()), 1);
    end
    start = 1'b0;
    in_valid = 1'b0;
    release_result("bp");
    step();
    chk("bp_still_idle", busy, 0);

    // Mid-run reset after beat 2, then a clean rerun.
    load_vec(0);
    start = 1'b1;
    k_len = KW'(3);
    step();
    start = 1'b0;
    feed_beats(0, 2, 0);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_c_zero", (c == '0), 1);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    step();
    rst = 1'b0;
    step();
    run("rerun", 3, 0);
    release_result("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
